// File: rtl/usb_ahb_lite_satellite.sv
// AHB-Lite zero-wait-state register satellite for the USB transceiver:
// DATA buffer, write/error counters, CTRL with inverted shadow, and a FLUSH strobe.
module usb_ahb_lite_satellite (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        hsel,
  input  logic [1:0]  htrans,
  input  logic [3:0]  haddr,
  input  logic        hsize,
  input  logic        hwrite,
  input  logic [31:0] hwdata,
  output logic [31:0] hrdata,
  output logic        hresp
);

  logic        vld_d, vld_q;
  logic [3:0]  addr_d, addr_q;
  logic        size_d, size_q;
  logic        write_d, write_q;
  logic [31:0] data_d, data_q;
  logic [15:0] wcount_d, wcount_q;
  logic [15:0] ecount_d, ecount_q;
  logic [7:0]  ctrl_d, ctrl_q;

  logic        err;
  logic        wr_ok;
  logic        rd_ok;
  logic [31:0] lane_mask;
  logic [31:0] word;

  // Legality of the access captured in the previous address phase.
  always_comb begin
    err = 1'b1;
    if (!size_q) begin
      case (addr_q)
        4'h0, 4'h1, 4'h2, 4'h3, 4'h8, 4'hC: err = 1'b0;
        4'h4, 4'h5, 4'h6, 4'h7, 4'h9:       err = write_q;
        default:                            err = 1'b1;
      endcase
    end else if (!addr_q[0]) begin
      case (addr_q)
        4'h0, 4'h2: err = 1'b0;
        4'h4, 4'h6: err = write_q;
        default:    err = 1'b1;
      endcase
    end
  end

  always_comb begin
    if (size_q) lane_mask = addr_q[1] ? 32'hFFFF_0000 : 32'h0000_FFFF;
    else        lane_mask = 32'h0000_00FF << {addr_q[1:0], 3'b000};

    case (addr_q[3:2])
      2'd0:    word = data_q;
      2'd1:    word = {ecount_q, wcount_q};
      2'd2:    word = {16'h0000, ~ctrl_q, ctrl_q};
      default: word = 32'h0000_0000;
    endcase

    wr_ok  = vld_q && !err && write_q;
    rd_ok  = vld_q && !err && !write_q;
    hrdata = rd_ok ? (word & lane_mask) : 32'h0000_0000;
    hresp  = vld_q && err;
  end

  always_comb begin
    vld_d   = hsel && (htrans == 2'b10 || htrans == 2'b11);
    addr_d  = haddr;
    size_d  = hsize;
    write_d = hwrite;

    data_d = data_q;
    ctrl_d = ctrl_q;
    if (wr_ok && addr_q[3:2] == 2'd0) data_d = (data_q & ~lane_mask) | (hwdata & lane_mask);
    if (wr_ok && addr_q == 4'h8)      ctrl_d = hwdata[7:0];
    if (wr_ok && addr_q == 4'hC && hwdata[0]) data_d = 32'h0000_0000;

    wcount_d = wcount_q + 16'(wr_ok);
    ecount_d = ecount_q + 16'(hresp);
  end

  always_ff @(posedge clk) begin
    if (n_rst) begin
      vld_q    <= 1'b0;
      data_q   <= 32'h0000_0000;
      wcount_q <= 16'h0000;
      ecount_q <= 16'h0000;
      ctrl_q   <= 8'h00;
    end else begin
      vld_q    <= vld_d;
      data_q   <= data_d;
      wcount_q <= wcount_d;
      ecount_q <= ecount_d;
      ctrl_q   <= ctrl_d;
    end
  end

  // Address-phase attributes are qualified by vld_q, so they need no reset.
  always_ff @(posedge clk) begin
    addr_q  <= addr_d;
    size_q  <= size_d;
    write_q <= write_d;
  end

endmodule

// File: tb/tb_usb_ahb_lite_satellite.sv
// Directed bench for usb_ahb_lite_satellite with hand-computed expected read data and responses.
module tb_usb_ahb_lite_satellite;

  logic        clk = 1'b0;
  logic        n_rst;
  logic        hsel;
  logic [1:0]  htrans;
  logic [3:0]  haddr;
  logic        hsize;
  logic        hwrite;
  logic [31:0] hwdata;
  logic [31:0] hrdata;
  logic        hresp;

  int errors = 0;
  int checks = 0;

  usb_ahb_lite_satellite dut (
    .clk    (clk),
    .n_rst  (n_rst),
    .hsel   (hsel),
    .htrans (htrans),
    .haddr  (haddr),
    .hsize  (hsize),
    .hwrite (hwrite),
    .hwdata (hwdata),
    .hrdata (hrdata),
    .hresp  (hresp)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Address phase driven after a negedge; data phase checked 1ns after the next posedge.
  task automatic xfer(input logic w, input logic [3:0] a, input logic s, input logic [31:0] wd,
                      input logic [31:0] exp_rd, input logic exp_resp, input string tag);
    hsel = 1'b1; htrans = 2'b10; haddr = a; hsize = s; hwrite = w;
    @(posedge clk); #1;
    hsel = 1'b0; htrans = 2'b00; hwdata = wd;
    chk({tag, "_resp"}, {31'b0, hresp}, {31'b0, exp_resp});
    if (!w) chk({tag, "_rdata"}, hrdata, exp_rd);
    @(negedge clk);
  endtask

  initial begin
    n_rst = 1'b1; hsel = 1'b0; htrans = 2'b00; haddr = 4'h0;
    hsize = 1'b0; hwrite = 1'b0; hwdata = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_resp", {31'b0, hresp}, 32'h0);
    chk("rst_rdata", hrdata, 32'h0);
    @(negedge clk);
    n_rst = 1'b0;

    xfer(0, 4'h0, 1, 0, 32'h0000_0000, 0, "rst_data");
    xfer(0, 4'h4, 1, 0, 32'h0000_0000, 0, "rst_wcount");
    xfer(0, 4'h8, 0, 0, 32'h0000_0000, 0, "rst_ctrl");
    xfer(0, 4'h9, 0, 0, 32'h0000_FF00, 0, "rst_shadow");

    xfer(1, 4'h2, 1, 32'hBEEF_0000, 0, 0, "wr_hw2");
    xfer(0, 4'h0, 1, 0, 32'h0000_0000, 0, "rd_hw0");
    xfer(0, 4'h2, 1, 0, 32'hBEEF_0000, 0, "rd_hw2");
    xfer(0, 4'h4, 1, 0, 32'h0000_0001, 0, "wcount1");

    xfer(1, 4'h8, 0, 32'h0000_005A, 0, 0, "wr_ctrl");
    xfer(0, 4'h8, 0, 0, 32'h0000_005A, 0, "rd_ctrl");
    xfer(0, 4'h9, 0, 0, 32'h0000_A500, 0, "rd_shadow");

    xfer(1, 4'h4, 0, 32'h0000_00FF, 0, 1, "err_wr_ro");
    xfer(0, 4'h3, 1, 0, 32'h0000_0000, 1, "err_misalign");
    xfer(0, 4'hE, 0, 0, 32'h0000_0000, 1, "err_unmapped");
    xfer(0, 4'h6, 1, 0, 32'h0003_0000, 0, "ecount3");
    xfer(0, 4'h4, 1, 0, 32'h0000_0002, 0, "wcount2");
    xfer(1, 4'hC, 1, 32'h0000_0001, 0, 1, "err_hw_flush");
    xfer(0, 4'h8, 1, 0, 32'h0000_0000, 1, "err_hw_ctrl");
    xfer(1, 4'h9, 0, 32'h0000_0000, 0, 1, "err_wr_shadow");
    xfer(0, 4'h6, 1, 0, 32'h0006_0000, 0, "ecount6");
    xfer(0, 4'h8, 0, 0, 32'h0000_005A, 0, "ctrl_kept");

    xfer(1, 4'h0, 1, 32'h0000_1234, 0, 0, "wr_hw0");
    xfer(0, 4'h0, 1, 0, 32'h0000_1234, 0, "rd_1234");
    xfer(0, 4'h2, 1, 0, 32'hBEEF_0000, 0, "rd_beef");
    xfer(1, 4'hC, 0, 32'h0000_0001, 0, 0, "flush");
    xfer(0, 4'h0, 1, 0, 32'h0000_0000, 0, "flushed_lo");
    xfer(0, 4'h2, 1, 0, 32'h0000_0000, 0, "flushed_hi");
    xfer(0, 4'hC, 0, 0, 32'h0000_0000, 0, "rd_flush");

    xfer(1, 4'h1, 0, 32'h0000_7700, 0, 0, "wr_b1");
    xfer(1, 4'hC, 0, 32'h0000_0002, 0, 0, "noflush");
    xfer(0, 4'h0, 1, 0, 32'h0000_7700, 0, "kept_b1");
    xfer(0, 4'h4, 1, 0, 32'h0000_0006, 0, "wcount6");

    // Back-to-back write then read of the same halfword.
    hsel = 1'b1; htrans = 2'b10; haddr = 4'h0; hsize = 1'b1; hwrite = 1'b1;
    @(posedge clk); #1;
    htrans = 2'b11; hwrite = 1'b0; hwdata = 32'h0000_00AA;
    chk("b2b_wr_resp", {31'b0, hresp}, 32'h0);
    @(posedge clk); #1;
    hsel = 1'b1; htrans = 2'b01;
    chk("b2b_rd_resp", {31'b0, hresp}, 32'h0);
    chk("b2b_rd_data", hrdata, 32'h0000_00AA);
    @(posedge clk); #1;
    hsel = 1'b0; htrans = 2'b00; hwrite = 1'b1; hwdata = 32'hFFFF_FFFF;
    chk("busy_resp", {31'b0, hresp}, 32'h0);
    chk("busy_rdata", hrdata, 32'h0);
    @(posedge clk); #1;
    chk("idle_resp", {31'b0, hresp}, 32'h0);
    chk("idle_rdata", hrdata, 32'h0);
    @(negedge clk);
    xfer(0, 4'h0, 1, 0, 32'h0000_00AA, 0, "idle_nochange");
    xfer(0, 4'h4, 1, 0, 32'h0000_0007, 0, "wcount7");

    // Reset asserted during a write data phase.
    hsel = 1'b1; htrans = 2'b10; haddr = 4'h8; hsize = 1'b0; hwrite = 1'b1;
    @(posedge clk); #1;
    hsel = 1'b0; htrans = 2'b00; hwdata = 32'h0000_00FF; n_rst = 1'b1;
    @(posedge clk); #1;
    chk("rst2_resp", {31'b0, hresp}, 32'h0);
    @(negedge clk);
    n_rst = 1'b0;
    xfer(0, 4'h8, 0, 0, 32'h0000_0000, 0, "rst2_ctrl");
    xfer(0, 4'h4, 1, 0, 32'h0000_0000, 0, "rst2_wcount");
    xfer(0, 4'h6, 1, 0, 32'h0000_0000, 0, "rst2_ecount");
    @(posedge clk); #1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
